scroll_marquee: RTL and testbench
=================================

# scroll_marquee

- Parametrised scrolling-text source for the multiplexed 7-segment display path.
- Holds a writable circular message of LEN character codes and presents a DIGITS-wide window of it on `data`.
- The window advances one character per internal divider period, left or right, with pause, restart and runtime message rewrite.
- Sits between the control logic that writes messages and the digit-scan/decoder block that consumes `data`.

## Interface
Parameters:
- CHAR_W, 5 — bits per character code.
- LEN, 14 — message length in characters; must be ≥ 2.
- DIGITS, 4 — window width in characters; must be ≥ 1. May exceed LEN; window indices wrap mod LEN.
- DIV, 24000000 — clk cycles per scroll step; must be ≥ 2.
- BLANK, 31 — character code for a dark digit.
- INIT, {LEN{BLANK}} — LEN*CHAR_W-bit reset message. Character 0 is in the MSBs.

Ports:
- clk, input, 1 — single clock, rising edge.
- rst_n, input, 1 — asynchronous, active-low reset.
- en, input, 1 — 1 = scroll, 0 = pause.
- dir, input, 1 — 0 = scroll left (head index increments); 1 = scroll right (head index decrements).
- restart, input, 1 — synchronous: head and divider return to 0.
- wr_en, input, 1 — message write strobe.
- wr_addr, input, $clog2(LEN) — character index to write.
- wr_data, input, CHAR_W — character code to write.
- data, output, DIGITS*CHAR_W — registered window. Leftmost digit is in the MSBs.
- pos, output, $clog2(LEN) — current head index, registered.
- tick, output, 1 — one-cycle pulse on each scroll step.

## Operation
- Storage:
  - LEN×CHAR_W message registers, loaded from INIT on reset.
  - `wr_en` writes `wr_data` into `msg[wr_addr]`.
  - Writes with `wr_addr ≥ LEN` are ignored.
- Divider:
  - `cnt` counts 0..DIV-1 and advances while `en`=1.
  - When `cnt`=DIV-1 and `en`=1, `cnt` wraps to 0 and `tick` asserts for the next cycle.
  - With `en`=0, `cnt` holds (see Configuration for the exception).
- Head update on a step: dir=0 → head = (head+1) mod LEN; dir=1 → head = (head+LEN-1) mod LEN.
  - Wrap: dir=0 goes LEN-1 → 0; dir=1 goes 0 → LEN-1.
  - `dir` is sampled only on the step cycle; changing `dir` mid-period is legal.
- Window: the digit k (k=0 leftmost) field of `data` = `msg[(head+k) mod LEN]`. The window is recomputed every cycle from the current head and message.
- Priority, highest first:
  1. `restart`: head←0, cnt←0; the pending step is discarded and `tick` stays 0.
  2. Step.
- A write and a step in the same cycle both take effect; the write lands at the addressed index regardless of head.
- `pos` = head.

## Timing
- Reset values (while `rst_n`=0, asynchronous): msg=INIT, head=0, cnt=0, `pos`=0, `tick`=0, `data`={DIGITS{BLANK}}, blink phase=0.
- `data` latency: 1 cycle from any head or message change.
  - A write at edge N shows on `data` after edge N+1.
  - A step at edge N updates `pos` at N and `data` at N+1.
- First window after reset release is valid 1 cycle after the first active clk edge.
- Step period: exactly DIV cycles while `en`=1 continuously.
- Pausing mid-period resumes from the held count; no step is lost or duplicated.
- `tick` rises in the same cycle that `pos` takes its new value.
- `restart` with `en`=1: the next step occurs DIV cycles after the restart edge.

## Configuration
- Macro `MARQUEE_BLINK_EN`.
- Defined:
  - The divider also runs while `en`=0.
  - Each wrap while paused toggles a blink phase; while the phase is 1, `data` = all BLANK (1-cycle latency as usual).
  - `tick` never pulses while paused.
  - `en`=1 or `restart` clears the phase immediately.
- Undefined: no blink logic; the divider holds while paused and `data` always shows the window.

## Test plan
- Reset, DIV=4, LEN=6, DIGITS=4, INIT codes 0..5, en=1, dir=0:
  - `data` = BLANK×4 in reset, then {0,1,2,3}.
  - After 4 cycles, `tick`=1, `pos`=1, and next cycle `data`={1,2,3,4}.
  - After 6 steps `pos` wraps to 0.
- dir=1 from `pos`=0: the next step gives `pos`=5, `data`={5,0,1,2}. Pause for 10 cycles mid-period: no `tick`; the resumed step arrives after the remaining count.
- Write wr_addr=2, wr_data=9 on a step cycle (0→1): `data`={1,9,3,4}. Write wr_addr=6: no change.
- `restart` asserted on the cycle cnt=DIV-1: no `tick`, `pos`=0, next step 4 cycles later.
- DIGITS=8, LEN=6: `data`={0,1,2,3,4,5,0,1}.
- `MARQUEE_BLINK_EN` defined, en=0, DIV=4: `data` alternates window/all-BLANK every 4 cycles; `pos` is constant; en=1 restores the window next cycle.

Source files
------------

// File: rtl/scroll_marquee.sv
// scroll_marquee: DIGITS-wide scrolling window over a writable LEN-char message.
// Define MARQUEE_BLINK_EN to blink the window dark/lit while paused.
module scroll_marquee #(
  parameter int CHAR_W = 5,
  parameter int LEN = 14,
  parameter int DIGITS = 4,
  parameter int DIV = 24000000,
  parameter int BLANK = 31,
  parameter logic [LEN*CHAR_W-1:0] INIT = {LEN{CHAR_W'(BLANK)}}
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       dir,
  input  logic                       restart,
  input  logic                       wr_en,
  input  logic [$clog2(LEN)-1:0]     wr_addr,
  input  logic [CHAR_W-1:0]          wr_data,
  output logic [DIGITS*CHAR_W-1:0]   data,
  output logic [$clog2(LEN)-1:0]     pos,
  output logic                       tick
);

  localparam int AW = $clog2(LEN);
  localparam int CW = $clog2(DIV);

  logic [CHAR_W-1:0]        msg [LEN];
  logic [AW-1:0]            head;
  logic [AW-1:0]            head_nxt;
  logic [CW-1:0]            cnt;
  logic                     wrap;
  logic                     run;
  logic                     step;
  logic                     blank_now;
  logic [DIGITS*CHAR_W-1:0] win;

  assign wrap = (cnt == CW'(DIV - 1));
  assign step = en & wrap & ~restart;
  assign pos  = head;

`ifdef MARQUEE_BLINK_EN
  logic phase;

  assign run       = 1'b1;
  assign blank_now = phase & ~en & ~restart;

  // Blink phase flips on each divider wrap while paused
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      phase <= 1'b0;
    else if (en || restart)
      phase <= 1'b0;
    else if (wrap)
      phase <= ~phase;
  end
`else
  assign run       = en;
  assign blank_now = 1'b0;
`endif

  // Step divider: counts 0..DIV-1, restart forces it back to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (restart)
      cnt <= '0;
    else if (run)
      cnt <= wrap ? '0 : cnt + 1'b1;
  end

  // Next head, circular in either direction
  always_comb begin
    head_nxt = head;
    if (dir)
      head_nxt = (head == '0) ? AW'(LEN - 1) : head - 1'b1;
    else
      head_nxt = (head == AW'(LEN - 1)) ? '0 : head + 1'b1;
  end

  // Head pointer and step pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tick <= 1'b0;
    end else begin
      tick <= step;
      if (restart)
        head <= '0;
      else if (step)
        head <= head_nxt;
    end
  end

  // Message store, out-of-range writes dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LEN; i++)
        msg[i] <= INIT[(LEN-1-i)*CHAR_W +: CHAR_W];
    end else if (wr_en && (int'(wr_addr) < LEN)) begin
      msg[wr_addr] <= wr_data;
    end
  end

  // Window gather, digit 0 in the MSBs
  always_comb begin
    int idx;
    win = '0;
    for (int k = 0; k < DIGITS; k++) begin
      idx = int'(head) + (k % LEN);
      if (idx >= LEN)
        idx = idx - LEN;
      win[(DIGITS-1-k)*CHAR_W +: CHAR_W] = msg[AW'(idx)];
    end
  end

  // Registered display output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      data <= {DIGITS{CHAR_W'(BLANK)}};
    else if (blank_now)
      data <= {DIGITS{CHAR_W'(BLANK)}};
    else
      data <= win;
  end

endmodule

// File: tb/tb_scroll_marquee.sv
// tb_scroll_marquee: directed plan plus random traffic vs a behavioural model.
// Works in both MARQUEE_BLINK_EN builds.
module tb_scroll_marquee;

  localparam int W   = 5;
  localparam int LEN = 6;
  localparam int DV  = 4;
  localparam int BL  = 31;
  localparam logic [LEN*W-1:0] INIT_T =
    {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, dir, restart, wr_en;
  logic [2:0]  wr_addr;
  logic [4:0]  wr_data;
  logic [19:0] data4;
  logic [39:0] data8;
  logic [2:0]  pos4, pos8;
  logic        tick4, tick8;

  int n_chk  = 0;
  int n_fail = 0;

  int ref_msg [LEN];
  int head, cnt, tick_e, ph;
  logic [19:0] exp4;
  logic [39:0] exp8;

  always #5 clk = ~clk;

  scroll_marquee #(
    .CHAR_W(W), .LEN(LEN), .DIGITS(4), .DIV(DV),
    .BLANK(BL), .INIT(INIT_T)
  ) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir),
    .restart(restart), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .data(data4), .pos(pos4), .tick(tick4)
  );

  scroll_marquee #(
    .CHAR_W(W), .LEN(LEN), .DIGITS(8), .DIV(DV),
    .BLANK(BL), .INIT(INIT_T)
  ) u_dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir),
    .restart(restart), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .data(data8), .pos(pos8), .tick(tick8)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] window(input int n, input bit dark);
    logic [39:0] r;
    r = '0;
    for (int k = 0; k < n; k++)
      r = (r << W) | 40'(dark ? BL : ref_msg[(head + k) % LEN]);
    return r;
  endfunction

  task automatic model();
    bit dark;
    dark = (ph != 0) && !en && !restart;
    exp4 = window(4, dark)[19:0];
    exp8 = window(8, dark);
    tick_e = 0;
    if (restart) begin
      head = 0;
      cnt  = 0;
      ph   = 0;
    end else if (en) begin
      ph = 0;
      if (cnt == DV - 1) begin
        cnt    = 0;
        tick_e = 1;
        head   = dir ? (head + LEN - 1) % LEN : (head + 1) % LEN;
      end else begin
        cnt++;
      end
    end else begin
`ifdef MARQUEE_BLINK_EN
      if (cnt == DV - 1) begin
        cnt = 0;
        ph  = 1 - ph;
      end else begin
        cnt++;
      end
`endif
    end
    if (wr_en && int'(wr_addr) < LEN)
      ref_msg[wr_addr] = int'(wr_data);
  endtask

  task automatic cyc();
    @(posedge clk);
    model();
    @(negedge clk);
    check("pos4", 64'(pos4), 64'(head));
    check("pos8", 64'(pos8), 64'(head));
    check("tick4", 64'(tick4), 64'(tick_e));
    check("tick8", 64'(tick8), 64'(tick_e));
    check("data4", 64'(data4), 64'(exp4));
    check("data8", 64'(data8), 64'(exp8));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++)
      cyc();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; dir = 1'b0; restart = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < LEN; i++)
      ref_msg[i] = i;
    head = 0; cnt = 0; tick_e = 0; ph = 0;
    repeat (3) @(negedge clk);
    check("rst_data4", 64'(data4), 64'(20'hFFFFF));
    check("rst_data8", 64'(data8), 64'(40'hFF_FFFF_FFFF));
    check("rst_pos", 64'(pos4), 64'd0);
    check("rst_tick", 64'(tick4), 64'd0);

    rst_n = 1'b1; en = 1'b1; dir = 1'b0;
    cyc();
    check("first_win", 64'(data4), 64'({5'd0, 5'd1, 5'd2, 5'd3}));
    check("wide_win", 64'(data8),
          64'({5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd0, 5'd1}));
    run(3);
    check("step1_tick", 64'(tick4), 64'd1);
    check("step1_pos", 64'(pos4), 64'd1);
    cyc();
    check("step1_data", 64'(data4), 64'({5'd1, 5'd2, 5'd3, 5'd4}));
    run(19);
    check("wrap_pos", 64'(pos4), 64'd0);
    check("wrap_tick", 64'(tick4), 64'd1);

    dir = 1'b1;
    run(4);
    check("right_pos", 64'(pos4), 64'd5);
    cyc();
    check("right_data", 64'(data4), 64'({5'd5, 5'd0, 5'd1, 5'd2}));
    en = 1'b0;
    run(10);
    en = 1'b1;
`ifndef MARQUEE_BLINK_EN
    check("paused_pos", 64'(pos4), 64'd5);
    run(2);
    check("resume_early", 64'(tick4), 64'd0);
    cyc();
    check("resume_tick", 64'(tick4), 64'd1);
    check("resume_pos", 64'(pos4), 64'd4);
`else
    run(3);
`endif

    restart = 1'b1; dir = 1'b0;
    cyc();
    restart = 1'b0;
    run(3);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 5'd9;
    cyc();
    wr_en = 1'b0;
    check("wrstep_pos", 64'(pos4), 64'd1);
    cyc();
    check("wrstep_data", 64'(data4), 64'({5'd1, 5'd9, 5'd3, 5'd4}));
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 5'd0;
    cyc();
    wr_en = 1'b0;
    cyc();
    check("oob_write", 64'(data4), 64'({5'd1, 5'd9, 5'd3, 5'd4}));

    restart = 1'b1;
    cyc();
    restart = 1'b0;
    check("rst_step_tick", 64'(tick4), 64'd0);
    check("rst_step_pos", 64'(pos4), 64'd0);
    run(3);
    check("after_rst_early", 64'(tick4), 64'd0);
    cyc();
    check("after_rst_tick", 64'(tick4), 64'd1);
    check("after_rst_pos", 64'(pos4), 64'd1);

    restart = 1'b1;
    cyc();
    restart = 1'b0; en = 1'b0;
    run(5);
    check("pause_pos", 64'(pos4), 64'd0);
`ifdef MARQUEE_BLINK_EN
    check("blink_dark", 64'(data4), 64'(20'hFFFFF));
`else
    check("pause_win", 64'(data4), 64'({5'd0, 5'd1, 5'd9, 5'd3}));
`endif
    en = 1'b1;
    cyc();
    check("unpause_win", 64'(data4), 64'({5'd0, 5'd1, 5'd9, 5'd3}));

    for (int i = 0; i < 400; i++) begin
      en      = ($urandom % 8) != 0;
      dir     = 1'($urandom % 2);
      restart = ($urandom % 32) == 0;
      wr_en   = ($urandom % 4) == 0;
      wr_addr = 3'($urandom % 8);
      wr_data = 5'($urandom % 32);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
